sram_ctrl: RTL and testbench

- Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM (256K x 16).
- Each 32-bit load or store is serialised into two 16-bit half accesses: low half first, then high half.
- While an access is in progress the block raises `pause`, which freezes the EXE/MEM/WB pipeline registers and the PC.
- It is the sole source of the pipeline `pause` signal.

---
 rtl/sram_ctrl_if.sv | 34 +++
 rtl/sram_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// MEM-stage / SRAM bus bundle for sram_ctrl.
// slave = controller view, master = pipeline + SRAM-pin view.
interface sram_ctrl_if;
   // pipeline side
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        pause;
   // SRAM pin side
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;
   logic        sram_oe_n;
   // statistics (tied to 0 unless SRAM_CTRL_STATS_EN)
   logic [31:0] rd_count;
   logic [31:0] wr_count;
   logic [31:0] stall_count;

   modport slave (
      input  wr_en, rd_en, address, write_data, sram_dq_in,
      output read_data, pause, sram_addr, sram_dq_out, sram_dq_oe,
             sram_we_n, sram_oe_n, rd_count, wr_count, stall_count
   );

   modport master (
      output wr_en, rd_en, address, write_data, sram_dq_in,
      input  read_data, pause, sram_addr, sram_dq_out, sram_dq_oe,
             sram_we_n, sram_oe_n, rd_count, wr_count, stall_count
   );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: serialises 32-bit MEM-stage loads/stores into two 16-bit
// accesses (low half, then high half) on an asynchronous 256K x 16 SRAM,
// freezing the pipeline through `pause` while an access is in flight.
// Optional feature macro: SRAM_CTRL_STATS_EN (read/write/stall counters).
module sram_ctrl #(
   parameter int unsigned BASE_ADDR     = 1024,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input logic        clk,
   input logic        rst,
   sram_ctrl_if.slave bus
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WORD_W = 17;
   localparam int unsigned ADDR_W = 18;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned DATA_W = 32;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

   // Reject phase lengths the strobe scheme cannot support.
   if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15) begin : g_bad_cycles
      $error("sram_ctrl: ACCESS_CYCLES must be in 2..15");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                is_wr;
   logic [WORD_W-1:0]   word;

   logic [DATA_W-1:0]   read_data_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [HALF_W-1:0]   dq_out_q;
   logic                dq_oe_q;
   logic                we_n_q;
   logic                oe_n_q;

   logic [DATA_W-1:0]   offset;
   logic [WORD_W-1:0]   req_word;
   logic                req;
   logic                last;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                strobe_nxt;
   logic                pause_c;
   logic                unused_addr_bits;

   // Request decode and word index of the incoming byte address.
   assign offset           = bus.address - DATA_W'(BASE_ADDR);
   assign req_word         = offset[18:2];
   assign unused_addr_bits = ^{offset[31:19], offset[1:0]};
   assign req              = bus.rd_en | bus.wr_en;

   // Phase timing: WE is low on every cycle of a phase but the last.
   assign last       = (cnt == LAST_CNT);
   assign cnt_nxt    = cnt + CNT_W'(1);
   assign strobe_nxt = (cnt_nxt < LAST_CNT);

   // Pipeline freeze: raised as soon as a request is seen, dropped in DONE.
   assign pause_c = (state == IDLE) ? req : (state != DONE);

   // Access sequencer with registered SRAM pin drive and read capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         is_wr       <= 1'b0;
         word        <= '0;
         read_data_q <= '0;
         addr_q      <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  // Write wins when both requests are present.
                  state    <= LOW;
                  cnt      <= '0;
                  is_wr    <= bus.wr_en;
                  word     <= req_word;
                  addr_q   <= {req_word, 1'b0};
                  dq_oe_q  <= bus.wr_en;
                  we_n_q   <= ~bus.wr_en;
                  oe_n_q   <= bus.wr_en;
                  dq_out_q <= bus.wr_en ? bus.write_data[15:0] : '0;
               end
            end

            LOW: begin
               if (last) begin
                  if (!is_wr) begin
                     read_data_q[15:0] <= bus.sram_dq_in;
                  end
                  state    <= HIGH;
                  cnt      <= '0;
                  addr_q   <= {word, 1'b1};
                  we_n_q   <= ~is_wr;
                  dq_out_q <= is_wr ? bus.write_data[31:16] : '0;
               end else begin
                  cnt      <= cnt_nxt;
                  we_n_q   <= ~(is_wr & strobe_nxt);
                  dq_out_q <= is_wr ? bus.write_data[15:0] : '0;
               end
            end

            HIGH: begin
               if (last) begin
                  if (!is_wr) begin
                     read_data_q[31:16] <= bus.sram_dq_in;
                  end
                  state    <= DONE;
                  cnt      <= '0;
                  addr_q   <= '0;
                  dq_out_q <= '0;
                  dq_oe_q  <= 1'b0;
                  we_n_q   <= 1'b1;
                  oe_n_q   <= 1'b1;
               end else begin
                  cnt      <= cnt_nxt;
                  we_n_q   <= ~(is_wr & strobe_nxt);
                  dq_out_q <= is_wr ? bus.write_data[31:16] : '0;
               end
            end

            DONE: begin
               // Pipeline advances on this edge; the next request is seen in IDLE.
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.pause       = pause_c;
   assign bus.read_data   = read_data_q;
   assign bus.sram_addr   = addr_q;
   assign bus.sram_dq_out = dq_out_q;
   assign bus.sram_dq_oe  = dq_oe_q;
   assign bus.sram_we_n   = we_n_q;
   assign bus.sram_oe_n   = oe_n_q;

`ifdef SRAM_CTRL_STATS_EN
   logic [DATA_W-1:0] rd_count_q;
   logic [DATA_W-1:0] wr_count_q;
   logic [DATA_W-1:0] stall_count_q;
   logic              enter_done;

   assign enter_done = (state == HIGH) && last;

   // Access and stall counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_q    <= '0;
         wr_count_q    <= '0;
         stall_count_q <= '0;
      end else begin
         if (enter_done && !is_wr) begin
            rd_count_q <= rd_count_q + DATA_W'(1);
         end
         if (enter_done && is_wr) begin
            wr_count_q <= wr_count_q + DATA_W'(1);
         end
         if (pause_c) begin
            stall_count_q <= stall_count_q + DATA_W'(1);
         end
      end
   end

   assign bus.rd_count    = rd_count_q;
   assign bus.wr_count    = wr_count_q;
   assign bus.stall_count = stall_count_q;
`else
   assign bus.rd_count    = '0;
   assign bus.wr_count    = '0;
   assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: directed accesses, a per-cycle expectation
// queue built from the access timing rules, and an SRAM array model.
module tb_sram_ctrl;

   localparam int unsigned AC   = 2;
   localparam int unsigned BASE = 1024;
`ifdef SRAM_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_ctrl_if bus ();

   sram_ctrl #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic        pause;
      logic [17:0] addr;
      logic [15:0] dq_out;
      logic        dq_oe;
      logic        we_n;
      logic        oe_n;
      logic        chk_rd;
      logic [31:0] rd;
      logic        done_rd;
      logic        done_wr;
      logic        rst_after;
   } exp_t;

   exp_t        expq[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_rd      = 32'h0;
   logic [15:0] ref_mem [int];
   logic [15:0] sram_mem [0:262143];

   // Asynchronous SRAM: reads follow OE, writes land while WE is low.
   assign bus.sram_dq_in = bus.sram_oe_n ? 16'h0 : sram_mem[bus.sram_addr];
   always @(posedge clk) begin
      if (bus.sram_dq_oe && !bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic exp_t idle_rec(input logic pause);
      exp_t e;
      e        = '0;
      e.pause  = pause;
      e.we_n   = 1'b1;
      e.oe_n   = 1'b1;
      e.chk_rd = 1'b1;
      e.rd     = exp_rd;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      for (int i = 0; i < n; i++) begin
         expq.push_back(idle_rec(1'b0));
         step();
      end
   endtask

   // One access: request cycle, two phases of AC cycles, then DONE.
   // abort_at >= 0 asserts rst in that phase cycle and ends the access.
   task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input int abort_at = -1);
      logic [31:0] off;
      logic [16:0] w;
      bit          is_w;
      exp_t        e;
      int          idx;
      is_w = wr;
      off  = addr - 32'(BASE);
      w    = 17'((off % 32'h0010_0000) / 32'd4);
      bus.wr_en      = wr;
      bus.rd_en      = rd;
      bus.address    = addr;
      bus.write_data = data;
      expq.push_back(idle_rec(1'b1));
      step();
      idx = 0;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < int'(AC); k++) begin
            e        = '0;
            e.pause  = 1'b1;
            e.addr   = {w, 1'(p)};
            e.dq_oe  = is_w;
            e.we_n   = !(is_w && k < int'(AC) - 1);
            e.oe_n   = is_w;
            e.dq_out = !is_w ? 16'h0 : (p == 0 ? data[15:0] : data[31:16]);
            if (idx == abort_at) begin
               e.rst_after = 1'b1;
               rst = 1'b1;
               expq.push_back(e);
               step();
               rst       = 1'b0;
               bus.wr_en = 1'b0;
               bus.rd_en = 1'b0;
               exp_rd    = 32'h0;
               return;
            end
            expq.push_back(e);
            step();
            idx++;
         end
      end
      if (is_w) begin
         ref_mem[int'({w, 1'b0})] = data[15:0];
         ref_mem[int'({w, 1'b1})] = data[31:16];
      end else begin
         exp_rd = {ref_mem[int'({w, 1'b1})], ref_mem[int'({w, 1'b0})]};
      end
      e         = idle_rec(1'b0);
      e.done_rd = !is_w;
      e.done_wr = is_w;
      expq.push_back(e);
      step();
   endtask

   // Per-cycle compare against the expectation queue.
   int   exp_rdc   = 0;
   int   exp_wrc   = 0;
   int   exp_stall = 0;
   exp_t cur;
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         cur = expq.pop_front();
         if (cur.done_rd) exp_rdc++;
         if (cur.done_wr) exp_wrc++;
         chk("pause", 32'(bus.pause), 32'(cur.pause));
         chk("sram_addr", 32'(bus.sram_addr), 32'(cur.addr));
         chk("sram_dq_oe", 32'(bus.sram_dq_oe), 32'(cur.dq_oe));
         chk("sram_we_n", 32'(bus.sram_we_n), 32'(cur.we_n));
         chk("sram_oe_n", 32'(bus.sram_oe_n), 32'(cur.oe_n));
         if (cur.dq_oe || !cur.pause) chk("sram_dq_out", 32'(bus.sram_dq_out), 32'(cur.dq_out));
         if (cur.chk_rd) chk("read_data", bus.read_data, cur.rd);
         chk("rd_count", bus.rd_count, STATS ? 32'(exp_rdc) : 32'h0);
         chk("wr_count", bus.wr_count, STATS ? 32'(exp_wrc) : 32'h0);
         chk("stall_count", bus.stall_count, STATS ? 32'(exp_stall) : 32'h0);
         if (cur.rst_after) begin
            exp_rdc   = 0;
            exp_wrc   = 0;
            exp_stall = 0;
         end else if (cur.pause) begin
            exp_stall++;
         end
      end
   end

   initial begin
      rst            = 1'b1;
      bus.rd_en      = 1'b0;
      bus.wr_en      = 1'b0;
      bus.address    = 32'h0;
      bus.write_data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      idle_cycles(10);

      access(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF);
      idle_cycles(2);
      chk("lit_mem2", 32'(sram_mem[2]), 32'h0000_BEEF);
      chk("lit_mem3", 32'(sram_mem[3]), 32'h0000_DEAD);

      access(1'b0, 1'b1, 32'd1028, 32'h0);
      chk("lit_load", bus.read_data, 32'hDEAD_BEEF);
      idle_cycles(1);

      access(1'b1, 1'b1, 32'd1024, 32'h1234_5678);
      idle_cycles(1);
      chk("lit_rw_rd", bus.read_data, 32'hDEAD_BEEF);
      chk("lit_mem0", 32'(sram_mem[0]), 32'h0000_5678);
      chk("lit_mem1", 32'(sram_mem[1]), 32'h0000_1234);

      access(1'b1, 1'b0, 32'd1032, 32'hA5A5_5A5A);
      access(1'b0, 1'b1, 32'd1032, 32'h0);
      idle_cycles(1);
      chk("lit_b2b", bus.read_data, 32'hA5A5_5A5A);

      access(1'b1, 1'b0, 32'd1020, 32'hCAFE_F00D);
      access(1'b0, 1'b1, 32'd1020, 32'h0);
      chk("lit_wrap_mem", 32'(sram_mem[18'h3FFFE]), 32'h0000_F00D);
      chk("lit_wrap_rd", bus.read_data, 32'hCAFE_F00D);

      access(1'b0, 1'b1, 32'd1024 + 32'h0010_0000 + 32'd7, 32'h0);
      chk("lit_alias_rd", bus.read_data, 32'hDEAD_BEEF);
      idle_cycles(1);

      access(1'b1, 1'b0, 32'd1036, 32'h1111_2222, 3);
      idle_cycles(3);
      chk("lit_rst_rd", bus.read_data, 32'h0);

      access(1'b0, 1'b1, 32'd1028, 32'h0);
      idle_cycles(2);
      chk("lit_recover", bus.read_data, 32'hDEAD_BEEF);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
